sram_wr_scheduler: RTL and testbench
====================================

// Module: sram_wr_scheduler
// PURPOSE
// - Shares one SRAM write port among NUM_PORTS requesters, each with a valid/ready handshake.
// - Arbitration mode is selected by sp0_wrr1:
//   - 0 = strict priority (SP).
//   - 1 = weighted round robin (WRR).
// - Sits between the ingress write queues and the SRAM controller.
// - Drives one registered write command per cycle toward the SRAM.
// PARAMETERS
// - NUM_PORTS  4    number of requesters (power of 2, 2..8)
// - DATA_W     256  write data width
// - ADDR_W     12   SRAM word address width
// - WEIGHT_W   4    WRR weight field width per port
// PORTS
// - clk         in   1                   single clock, rising edge
// - rst         in   1                   synchronous, active-low reset (0 = reset)
// - sp0_wrr1    in   1                   arbitration mode, 0=SP, 1=WRR
// - wrr_weight  in   NUM_PORTS*WEIGHT_W  per-port WRR weight, port i at [i*WEIGHT_W +: WEIGHT_W]
// - req_valid   in   NUM_PORTS           requester i has a write pending
// - req_ready   out  NUM_PORTS           requester i write accepted this cycle (one-hot or 0)
// - req_addr    in   NUM_PORTS*ADDR_W    per-port write address
// - req_data    in   NUM_PORTS*DATA_W    per-port write data
// - sram_valid  out  1                   write command valid
// - sram_ready  in   1                   SRAM controller accepts command
// - sram_addr   out  ADDR_W              command address
// - sram_data   out  DATA_W              command data
// - sram_src    out  $clog2(NUM_PORTS)   index of the port that issued the command
// BEHAVIOUR
// - Reset (rst==0 at a clk edge):
//   - sram_valid, sram_addr, sram_data and sram_src go to 0.
//   - All WRR credits go to 0; rr pointer goes to 0.
//   - req_ready is 0 while rst==0.
// - accept = ~sram_valid | sram_ready.
//   - A grant is issued only when accept==1 and at least one req_valid is set.
// - req_ready[g] = accept & grant[g]. Transfer on port g when req_valid[g] & req_ready[g].
//   - Grant is combinational from the current req_valid; no request is ever dropped.
// - Latency 1: a transfer at edge N gives sram_valid=1 with that addr/data/src after edge N.
//   - Output holds stable while sram_valid & ~sram_ready.
//   - Back-to-back transfers run at 1 per cycle when sram_ready stays 1.
// - SP mode: the lowest-index valid port wins. Credits and pointer are untouched.
// - WRR mode:
//   - Eligible = req_valid & (credit != 0).
//   - If eligible==0 but req_valid!=0, reload every credit from wrr_weight this cycle and grant from the reloaded values.
//     - Weight 0 is treated as 1.
//   - Pick the first eligible port scanning upward from ptr, with wrap-around.
//   - On transfer, credit[g] decrements by 1.
//     - If the new credit is 0, ptr = (g+1) mod NUM_PORTS.
//     - Otherwise ptr = g, so the port keeps the grant for its burst.
//   - A granted port that drops valid loses its turn; the next scan starts at ptr.
// - Mode switch:
//   - sp0_wrr1 is sampled every cycle.
//   - On a 0->1 transition, all credits are cleared, forcing a reload on the next WRR grant. ptr is kept.
// - No transfer when accept==0: credits and ptr hold.
// - Reset mid-transfer: a pending sram_valid command is discarded. Requesters must re-present.
// STRUCTURE
// - Shared include sram_ctl_defs.vh: MODE_SP=1'b0, MODE_WRR=1'b1, default DATA_W/ADDR_W.
// - Sub-module rr_pick: NUM_PORTS-wide round-robin first-one finder.
//   - Inputs: req vector, start pointer.
//   - Outputs: one-hot grant, encoded index, any.
//   - SP mode reuses it with start=0.
// - Top level holds credit registers, ptr, output register and handshake logic.
// TESTING
// - Reset: hold rst=0 for 3 cycles with all req_valid=1.
//   -> req_ready=0 and sram_valid=0 throughout; first grant is on the cycle after rst=1.
// - SP: sp0_wrr1=0, req_valid=4'b1010, sram_ready=1 for 4 cycles.
//   -> sram_src=1,1,1,1; port 3 starved; req_ready=4'b0010.
// - WRR: weights {p3..p0}={1,2,3,4}, all valid, sram_ready=1, 20 cycles.
//   -> sram_src sequence 0,0,0,0,1,1,1,2,2,3 repeated twice.
// - Backpressure: sram_ready=0 for 5 cycles mid-stream.
//   -> sram_addr/data/src stable, req_ready=0, credits unchanged; stream resumes with no loss or duplicate.
// - Weight 0 / sparse: weights all 0, req_valid=4'b0101.
//   -> sram_src alternates 0,2,0,2; a reload occurs every two grants.
// - Mode switch mid-burst: WRR with port0 credit 2 left, then set sp0_wrr1=0 for 2 cycles, then back to 1.
//   -> credits reload and the scan resumes from the kept ptr.

Source files
------------

// File: rtl/sram_wr_scheduler_pkg.sv
// ---------------------------------------------------------------------------
// sram_wr_scheduler_pkg
// Shared definitions for the SRAM write scheduler:
//   - arbitration mode encodings (strict priority / weighted round robin)
//   - default sizing parameters for the scheduler and its picker
// No ports; imported by every file of the scheduler.
// ---------------------------------------------------------------------------
package sram_wr_scheduler_pkg;

   // Value of i_sp0_wrr1 selecting each arbitration mode
   localparam logic MODE_SP  = 1'b0;
   localparam logic MODE_WRR = 1'b1;

   // Default sizing
   localparam int DEF_NUM_PORTS = 4;
   localparam int DEF_DATA_W    = 256;
   localparam int DEF_ADDR_W    = 12;
   localparam int DEF_WEIGHT_W  = 4;

endpackage

// File: rtl/sram_wr_scheduler_rr_pick.sv
// ---------------------------------------------------------------------------
// sram_wr_scheduler_rr_pick
// Round-robin first-one finder: scans i_req upward starting at i_start,
// wrapping around, and reports the first set bit.
// Ports:
//   i_req    [NUM_PORTS]        request vector
//   i_start  [$clog2(NUM_PORTS)] index where the scan begins
//   o_grant  [NUM_PORTS]        one-hot grant (0 when no request)
//   o_idx    [$clog2(NUM_PORTS)] encoded index of the granted bit
//   o_any                       at least one request is set
// Strict priority is obtained by driving i_start with 0.
// ---------------------------------------------------------------------------
module sram_wr_scheduler_rr_pick
   import sram_wr_scheduler_pkg::*;
#(
   parameter int NUM_PORTS = DEF_NUM_PORTS
)(
   input  logic [NUM_PORTS-1:0]         i_req,
   input  logic [$clog2(NUM_PORTS)-1:0] i_start,
   output logic [NUM_PORTS-1:0]         o_grant,
   output logic [$clog2(NUM_PORTS)-1:0] o_idx,
   output logic                         o_any
);

   localparam int IDX_W = $clog2(NUM_PORTS);

   logic [IDX_W-1:0] w_cand;

   // Walk the ports in scan order; NUM_PORTS is a power of two, so the
   // candidate index wraps naturally by overflowing its width.
   always_comb begin
      o_grant = '0;
      o_idx   = '0;
      o_any   = 1'b0;
      w_cand  = '0;
      for (int k = 0; k < NUM_PORTS; k++) begin
         w_cand = i_start + IDX_W'(k);
         if (!o_any && i_req[w_cand]) begin
            o_any           = 1'b1;
            o_idx           = w_cand;
            o_grant[w_cand] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/sram_wr_scheduler.sv
// ---------------------------------------------------------------------------
// sram_wr_scheduler
// Shares one SRAM write port among NUM_PORTS valid/ready requesters using
// either strict priority or weighted round robin, and drives one registered
// write command per cycle toward the SRAM controller.
// Ports:
//   i_clk         clock, rising edge
//   i_rst         synchronous active-low reset (0 = reset)
//   i_sp0_wrr1    arbitration mode, 0 = strict priority, 1 = WRR
//   i_wrr_weight  per-port WRR weight, port i at [i*WEIGHT_W +: WEIGHT_W]
//   i_req_valid   per-port write pending
//   o_req_ready   per-port write accepted this cycle (one-hot or 0)
//   i_req_addr    per-port write address
//   i_req_data    per-port write data
//   o_sram_valid  write command valid
//   i_sram_ready  SRAM controller accepts the command
//   o_sram_addr   command address
//   o_sram_data   command data
//   o_sram_src    index of the port that issued the command
// ---------------------------------------------------------------------------
module sram_wr_scheduler
   import sram_wr_scheduler_pkg::*;
#(
   parameter int NUM_PORTS = DEF_NUM_PORTS,
   parameter int DATA_W    = DEF_DATA_W,
   parameter int ADDR_W    = DEF_ADDR_W,
   parameter int WEIGHT_W  = DEF_WEIGHT_W
)(
   input  logic                          i_clk,
   input  logic                          i_rst,
   input  logic                          i_sp0_wrr1,
   input  logic [NUM_PORTS*WEIGHT_W-1:0] i_wrr_weight,
   input  logic [NUM_PORTS-1:0]          i_req_valid,
   output logic [NUM_PORTS-1:0]          o_req_ready,
   input  logic [NUM_PORTS*ADDR_W-1:0]   i_req_addr,
   input  logic [NUM_PORTS*DATA_W-1:0]   i_req_data,
   output logic                          o_sram_valid,
   input  logic                          i_sram_ready,
   output logic [ADDR_W-1:0]             o_sram_addr,
   output logic [DATA_W-1:0]             o_sram_data,
   output logic [$clog2(NUM_PORTS)-1:0]  o_sram_src
);

   localparam int IDX_W = $clog2(NUM_PORTS);

   logic [WEIGHT_W-1:0] r_credit [NUM_PORTS];
   logic [IDX_W-1:0]    r_ptr;
   logic                r_modePrev;
   logic                r_sramValid;
   logic [ADDR_W-1:0]   r_sramAddr;
   logic [DATA_W-1:0]   r_sramData;
   logic [IDX_W-1:0]    r_sramSrc;

   logic                w_isWrr;
   logic                w_modeRise;
   logic                w_accept;
   logic                w_reload;
   logic                w_any;
   logic                w_xfer;
   logic                w_lastCredit;
   logic [WEIGHT_W-1:0] w_wtEff    [NUM_PORTS];
   logic [WEIGHT_W-1:0] w_credEff  [NUM_PORTS];
   logic [WEIGHT_W-1:0] w_credUse  [NUM_PORTS];
   logic [WEIGHT_W-1:0] w_credNext [NUM_PORTS];
   logic [NUM_PORTS-1:0] w_eligPre;
   logic [NUM_PORTS-1:0] w_elig;
   logic [NUM_PORTS-1:0] w_pickReq;
   logic [NUM_PORTS-1:0] w_grant;
   logic [IDX_W-1:0]    w_pickStart;
   logic [IDX_W-1:0]    w_gIdx;

   assign w_isWrr    = (i_sp0_wrr1 == MODE_WRR);
   assign w_modeRise = w_isWrr && (r_modePrev == MODE_SP);
   assign w_accept   = ~r_sramValid | i_sram_ready;

   // A switch into WRR mode behaves as if all credits were already cleared,
   // so the very first WRR grant after the switch reloads from the weights.
   always_comb begin
      for (int i = 0; i < NUM_PORTS; i++) begin
         w_wtEff[i]   = i_wrr_weight[i*WEIGHT_W +: WEIGHT_W];
         if (w_wtEff[i] == '0) begin
            w_wtEff[i] = WEIGHT_W'(1);
         end
         w_credEff[i] = w_modeRise ? '0 : r_credit[i];
         w_eligPre[i] = i_req_valid[i] && (w_credEff[i] != '0);
      end
   end

   // When every requester has spent its credit, all credits are refilled in
   // the same cycle and the grant is made from the refilled values.
   assign w_reload = (w_eligPre == '0) && (i_req_valid != '0);

   always_comb begin
      for (int i = 0; i < NUM_PORTS; i++) begin
         w_credUse[i] = w_reload ? w_wtEff[i] : w_credEff[i];
         w_elig[i]    = i_req_valid[i] && (w_credUse[i] != '0);
      end
   end

   // Strict priority reuses the round-robin picker with a fixed start of 0
   assign w_pickReq   = w_isWrr ? w_elig : i_req_valid;
   assign w_pickStart = w_isWrr ? r_ptr  : '0;

   sram_wr_scheduler_rr_pick #(
      .NUM_PORTS (NUM_PORTS)
   ) u_pick (
      .i_req   (w_pickReq),
      .i_start (w_pickStart),
      .o_grant (w_grant),
      .o_idx   (w_gIdx),
      .o_any   (w_any)
   );

   assign w_xfer      = i_rst && w_accept && w_any;
   assign o_req_ready = w_xfer ? w_grant : '0;

   // Spend one credit of the granted port; a port keeps the pointer while it
   // still has credit so it can finish its burst.
   always_comb begin
      for (int i = 0; i < NUM_PORTS; i++) begin
         w_credNext[i] = w_credUse[i];
         if (i == int'(w_gIdx)) begin
            w_credNext[i] = w_credUse[i] - WEIGHT_W'(1);
         end
      end
   end

   assign w_lastCredit = (w_credUse[w_gIdx] == WEIGHT_W'(1));

   // Output command register, WRR credits and scan pointer. Credits only move
   // on a WRR transfer, except for the clear that accompanies a mode switch.
   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         r_sramValid <= 1'b0;
         r_sramAddr  <= '0;
         r_sramData  <= '0;
         r_sramSrc   <= '0;
         r_ptr       <= '0;
         r_modePrev  <= MODE_SP;
         for (int i = 0; i < NUM_PORTS; i++) begin
            r_credit[i] <= '0;
         end
      end else begin
         r_modePrev <= i_sp0_wrr1;
         if (w_xfer) begin
            r_sramValid <= 1'b1;
            r_sramAddr  <= i_req_addr[int'(w_gIdx)*ADDR_W +: ADDR_W];
            r_sramData  <= i_req_data[int'(w_gIdx)*DATA_W +: DATA_W];
            r_sramSrc   <= w_gIdx;
         end else if (i_sram_ready) begin
            r_sramValid <= 1'b0;
         end
         if (w_xfer && w_isWrr) begin
            for (int i = 0; i < NUM_PORTS; i++) begin
               r_credit[i] <= w_credNext[i];
            end
            r_ptr <= w_lastCredit ? (w_gIdx + IDX_W'(1)) : w_gIdx;
         end else if (w_modeRise) begin
            for (int i = 0; i < NUM_PORTS; i++) begin
               r_credit[i] <= '0;
            end
         end
      end
   end

   assign o_sram_valid = r_sramValid;
   assign o_sram_addr  = r_sramAddr;
   assign o_sram_data  = r_sramData;
   assign o_sram_src   = r_sramSrc;

endmodule

// File: tb/tb_sram_wr_scheduler.sv
// ---------------------------------------------------------------------------
// tb_sram_wr_scheduler
// Self-checking bench for sram_wr_scheduler. A driver applies directed and
// random stimulus, a behavioural model predicts grants and pushes expected
// commands into a queue, and an independent monitor compares every command
// the DUT presents on the SRAM side against that queue.
// ---------------------------------------------------------------------------
module tb_sram_wr_scheduler;

   localparam int NP = 4;
   localparam int DW = 256;
   localparam int AW = 12;
   localparam int WW = 4;

   typedef struct packed {
      logic [1:0]    src;
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
   } cmd_t;

   logic             clk = 1'b0;
   logic             rstN = 1'b0;
   logic             mode = 1'b0;
   logic [NP*WW-1:0] weight = '0;
   logic [NP-1:0]    valid = '0;
   logic [NP-1:0]    reqReady;
   logic [NP*AW-1:0] addrBus = '0;
   logic [NP*DW-1:0] dataBus = '0;
   logic             sramValid;
   logic             sramReady = 1'b0;
   logic [AW-1:0]    sramAddr;
   logic [DW-1:0]    sramData;
   logic [1:0]       sramSrc;

   cmd_t expQ[$];
   int   srcLog[$];
   int   nChecks = 0;
   int   nFails  = 0;

   // Behavioural model state
   int   credit[NP];
   int   ptr = 0;
   bit   prevMode = 1'b0;
   bit   outValid = 1'b0;
   bit   modelKnown = 1'b0;

   always #5 clk = ~clk;

   sram_wr_scheduler dut (
      .i_clk        (clk),
      .i_rst        (rstN),
      .i_sp0_wrr1   (mode),
      .i_wrr_weight (weight),
      .i_req_valid  (valid),
      .o_req_ready  (reqReady),
      .i_req_addr   (addrBus),
      .i_req_data   (dataBus),
      .o_sram_valid (sramValid),
      .i_sram_ready (sramReady),
      .o_sram_addr  (sramAddr),
      .o_sram_data  (sramData),
      .o_sram_src   (sramSrc)
   );

   task automatic checkOutput(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      nChecks++;
      if (act !== exp) begin
         nFails++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // One clock cycle: drive inputs, predict the grant from the arbitration
   // rules, check the handshake, then advance the model at the clock edge.
   task automatic applyStimulus(input logic r, input logic m, input logic [NP-1:0] v,
                                input logic sr, input logic [NP*WW-1:0] w);
      int   cred[NP];
      int   win;
      int   p;
      bit   acc;
      bit   anyElig;
      logic [NP-1:0] expReady;
      cmd_t c;
      @(negedge clk);
      rstN = r; mode = m; valid = v; sramReady = sr; weight = w;
      for (int i = 0; i < NP; i++) begin
         addrBus[i*AW +: AW] = AW'($urandom);
         for (int j = 0; j < DW/32; j++) begin
            dataBus[i*DW + j*32 +: 32] = $urandom;
         end
      end
      #1;
      for (int i = 0; i < NP; i++) cred[i] = (m && !prevMode) ? 0 : credit[i];
      acc = !outValid || sr;
      win = -1;
      if (r && acc && v != '0) begin
         if (!m) begin
            for (int i = NP-1; i >= 0; i--) if (v[i]) win = i;
         end else begin
            anyElig = 1'b0;
            for (int i = 0; i < NP; i++) if (v[i] && cred[i] > 0) anyElig = 1'b1;
            if (!anyElig) begin
               for (int i = 0; i < NP; i++) begin
                  cred[i] = int'(w[i*WW +: WW]);
                  if (cred[i] == 0) cred[i] = 1;
               end
            end
            for (int k = 0; k < NP; k++) begin
               p = (ptr + k) % NP;
               if (win < 0 && v[p] && cred[p] > 0) win = p;
            end
         end
      end
      expReady = (win >= 0) ? NP'(1 << win) : '0;
      checkOutput("req_ready", reqReady, expReady);
      if (modelKnown) checkOutput("sram_valid", sramValid, outValid);
      @(posedge clk);
      if (!r) begin
         for (int i = 0; i < NP; i++) credit[i] = 0;
         ptr = 0; prevMode = 1'b0; outValid = 1'b0; modelKnown = 1'b1;
         expQ.delete();
      end else begin
         if (win >= 0) begin
            c.src  = 2'(win);
            c.addr = addrBus[win*AW +: AW];
            c.data = dataBus[win*DW +: DW];
            expQ.push_back(c);
            outValid = 1'b1;
            if (m) begin
               for (int i = 0; i < NP; i++) credit[i] = cred[i];
               credit[win]--;
               ptr = (credit[win] == 0) ? (win + 1) % NP : win;
            end
         end else begin
            if (sr) outValid = 1'b0;
            if (m && !prevMode) for (int i = 0; i < NP; i++) credit[i] = 0;
         end
         prevMode = m;
      end
   endtask

   task automatic checkSrcSeq(input string name, input int exp[$]);
      checkOutput({name, "_len"}, DW'(srcLog.size()), DW'(exp.size()));
      for (int i = 0; i < exp.size() && i < srcLog.size(); i++) begin
         checkOutput(name, DW'(srcLog[i]), DW'(exp[i]));
      end
   endtask

   // Monitor: every presented command must match the head of the queue; it
   // is retired only when the SRAM side accepts it, so held commands are
   // compared on every stalled cycle.
   initial begin
      forever begin
         @(negedge clk);
         #2;
         if (rstN === 1'b1 && sramValid === 1'b1) begin
            if (expQ.size() == 0) begin
               nChecks++;
               nFails++;
               $display("[TB] FAIL unexpected_cmd: got src %0d expected no command at %0t", sramSrc, $time);
            end else begin
               checkOutput("sram_src", DW'(sramSrc), DW'(expQ[0].src));
               checkOutput("sram_addr", DW'(sramAddr), DW'(expQ[0].addr));
               checkOutput("sram_data", sramData, expQ[0].data);
               if (sramReady) begin
                  srcLog.push_back(int'(sramSrc));
                  void'(expQ.pop_front());
               end
            end
         end
      end
   end

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int exp[$];
      logic rr;
      logic mm;
      logic [NP*WW-1:0] ww;

      // Reset held with every requester asking
      for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 4'hF, 1'b1, 16'h1234);

      // Strict priority: port 1 always beats port 3
      srcLog.delete();
      for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0, 4'b1010, 1'b1, 16'h1234);
      applyStimulus(1'b1, 1'b0, 4'b0000, 1'b1, 16'h1234);
      exp = '{1, 1, 1, 1};
      checkSrcSeq("sp_seq", exp);

      // WRR with weights p3..p0 = 1,2,3,4
      srcLog.delete();
      for (int i = 0; i < 20; i++) applyStimulus(1'b1, 1'b1, 4'hF, 1'b1, 16'h1234);
      applyStimulus(1'b1, 1'b1, 4'b0000, 1'b1, 16'h1234);
      exp = '{0,0,0,0,1,1,1,2,2,3, 0,0,0,0,1,1,1,2,2,3};
      checkSrcSeq("wrr_seq", exp);

      // Backpressure mid-stream
      for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1, 4'hF, 1'b1, 16'h1234);
      for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b1, 4'hF, 1'b0, 16'h1234);
      for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b1, 4'hF, 1'b1, 16'h1234);

      // Reset while a command is still pending
      applyStimulus(1'b1, 1'b1, 4'hF, 1'b0, 16'h1234);
      applyStimulus(1'b0, 1'b1, 4'hF, 1'b0, 16'h1234);

      // All-zero weights, sparse requesters
      srcLog.delete();
      for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b1, 4'b0101, 1'b1, 16'h0000);
      applyStimulus(1'b1, 1'b1, 4'b0000, 1'b1, 16'h0000);
      exp = '{0, 2, 0, 2};
      checkSrcSeq("sparse_seq", exp);

      // Mode switch in the middle of port 0's burst
      applyStimulus(1'b0, 1'b1, 4'hF, 1'b1, 16'h1234);
      srcLog.delete();
      for (int i = 0; i < 2; i++) applyStimulus(1'b1, 1'b1, 4'hF, 1'b1, 16'h1234);
      for (int i = 0; i < 2; i++) applyStimulus(1'b1, 1'b0, 4'hF, 1'b1, 16'h1234);
      for (int i = 0; i < 6; i++) applyStimulus(1'b1, 1'b1, 4'hF, 1'b1, 16'h1234);
      applyStimulus(1'b1, 1'b1, 4'b0000, 1'b1, 16'h1234);
      exp = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 1};
      checkSrcSeq("modesw_seq", exp);

      // Random traffic
      mm = 1'b1;
      ww = 16'h1234;
      for (int i = 0; i < 500; i++) begin
         if ($urandom_range(0, 19) == 0) mm = ~mm;
         if ($urandom_range(0, 31) == 0) ww = 16'($urandom);
         rr = ($urandom_range(0, 99) != 0);
         applyStimulus(rr, mm, 4'($urandom), ($urandom_range(0, 3) != 0), ww);
      end

      // Drain and confirm nothing was lost
      for (int i = 0; i < 3; i++) applyStimulus(1'b1, mm, 4'b0000, 1'b1, ww);
      checkOutput("queue_empty", DW'(expQ.size()), DW'(0));

      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

endmodule
